rgb_pwm_capture: RTL and testbench
==================================

# rgb_pwm_capture

Three-channel PWM duty-cycle decoder. It measures the red, green and blue PWM waveforms produced by the team's 8-bit RGB PWM driver and recovers the intensity code of each channel. The block sits on the loopback/monitor path: LED drive pins, or an external PWM source, in; intensity words, out to the seven-segment display or the self-check logic. The PWM frame is 2^WIDTH clocks long, with the output high for `duty` clocks.

## Interface
- `WIDTH`, default 8: intensity width; measurement window = 2^WIDTH clocks.
- `clk` input 1: system clock; the PWM source must run on the same frequency.
- `rst` input 1: asynchronous, active-low reset.
- `red_pwm`, `green_pwm`, `blue_pwm` input 1 each: PWM inputs, asynchronous to `clk` phase.
- `red_intensity`, `green_intensity`, `blue_intensity` output WIDTH each: decoded duty, registered.
- `sample_valid` output 1: one-cycle pulse when new intensities are latched.
- `red_err`, `green_err`, `blue_err` output 1 each: the last window held more than one rising edge.
- `red_full`, `green_full`, `blue_full` output 1 each: the last window was high on every cycle (saturated).

## Operation
- Input conditioning, per channel:
  - 2-flop synchronizer, then a registered copy for rising-edge detection (`s & ~s_d`).
- Window counter:
  - One shared counter `win_cnt`, WIDTH bits, free-running 0 → 2^WIDTH−1, then wraps to 0.
  - `win_end` = (`win_cnt` == 2^WIDTH−1).
- Per-channel accumulators:
  - `hi_cnt`, WIDTH+1 bits: +1 on each cycle the synchronized input is 1.
  - `edge_cnt`, 2 bits: counts rising edges and saturates at 2.
- Window end, with that cycle's sample included:
  - intensity ← `hi_total`, where `hi_total` = `hi_cnt` + current sample.
  - If `hi_total` == 2^WIDTH: intensity ← 2^WIDTH−1 and full ← 1; otherwise full ← 0.
  - err ← (`edge_total` ≥ 2), where `edge_total` includes the current-cycle edge.
  - `hi_cnt` and `edge_cnt` restart at 0 on the next cycle.
- Phase independence:
  - A 2^WIDTH-periodic waveform has exactly `duty` high cycles in any 2^WIDTH window, so no alignment to the source's frame is needed.
- Limits and non-periodic inputs:
  - Duty 0 gives intensity 0, err 0, full 0.
  - A stuck-high input gives intensity 2^WIDTH−1 with full = 1.
  - A non-periodic or glitchy input gives the raw high-cycle count, with err flagged.
- Sample outputs hold their value between `sample_valid` pulses.
- There is no back-pressure; the consumer must capture the values on `sample_valid`.

## Timing
- Reset (`rst` = 0, asynchronous):
  - All synchronizers, counters, intensities, err, full and `sample_valid` go to 0.
  - `win_cnt` = 0.
- Release:
  - The first window ends 2^WIDTH clocks after reset deasserts.
  - Its result includes the synchronizer fill (2 cycles of 0). The first sample is therefore valid only for duty 0; consumers discard it.
  - The second and later samples are exact.
- Latency:
  - Pin to synchronized input: 2 clocks.
  - Window-end cycle to output: registered 1 clock later, with `sample_valid` high in that same cycle.
- Simultaneous events:
  - A sample and a rising edge on the `win_end` cycle both count in the closing window.
- Reset mid-window:
  - Aborts the window with no partial sample and no `sample_valid`.
  - Counting restarts from `win_cnt` = 0.
- `sample_valid` period: exactly 2^WIDTH clocks.

## Structure
- Sub-module `pwm_capture` (one channel):
  - Contains the synchronizer, edge detect, `hi_cnt`, `edge_cnt` and the output registers.
  - Input: `win_end`; outputs: intensity, err, full.
- Top `rgb_pwm_capture`:
  - Owns `win_cnt` and `sample_valid`, and instantiates three `pwm_capture`.
- No shared package is needed.
  - Local constants: `WIN_LEN` = 1 << WIDTH and `SAT` = WIN_LEN − 1, derived from `WIDTH` in each module.

## Test plan
- RGB PWM driver looped back, duties R = 0x40, G = 0x80, B = 0x01, WIDTH = 8 -> second and later samples read 0x40/0x80/0x01; err = 0, full = 0.
- Inputs held 0 -> every sample reads 0x00, err = 0, full = 0.
- Inputs held 1 -> from the second sample on, 0xFF with full = 1.
- Loopback duty 0x20 started at frame offsets 0, 100 and 255 relative to `win_cnt` -> all read 0x20.
- Two 5-cycle pulses per 256-cycle window on red -> `red_intensity` = 0x0A, `red_err` = 1; green and blue unaffected.
- Assert `rst` at `win_cnt` = 130 for 3 cycles -> outputs 0 immediately, no `sample_valid`; the next pulse arrives 256 clocks after release.

Source files
------------

// File: rtl/pwm_capture.sv
// One PWM channel: synchronizes the pin, counts high cycles and rising edges
// over a window, and registers the decoded duty when the window closes.
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             win_end,
  output logic [WIDTH-1:0] intensity,
  output logic             err,
  output logic             full
);

  localparam int WIN_LEN = 1 << WIDTH;
  localparam int SAT     = WIN_LEN - 1;
  localparam logic [WIDTH:0]   FULL_CNT = (WIDTH+1)'(WIN_LEN);
  localparam logic [WIDTH-1:0] SAT_V    = WIDTH'(SAT);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [WIDTH:0]   hi_cnt_q, hi_cnt_d;
  logic [1:0]       edge_cnt_q, edge_cnt_d;
  logic [WIDTH-1:0] intensity_q, intensity_d;
  logic             err_q, err_d;
  logic             full_q, full_d;

  logic             rise;
  logic [WIDTH:0]   hi_total;
  logic [2:0]       edge_total;

  always_comb begin
    rise       = sync2_q & ~prev_q;
    hi_total   = hi_cnt_q + {{WIDTH{1'b0}}, sync2_q};
    edge_total = {1'b0, edge_cnt_q} + {2'b00, rise};

    sync1_d     = pwm_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    hi_cnt_d    = hi_total;
    edge_cnt_d  = (edge_total >= 3'd2) ? 2'd2 : edge_total[1:0];
    intensity_d = intensity_q;
    err_d       = err_q;
    full_d      = full_q;

    // The closing cycle's own sample and edge belong to the window being reported.
    if (win_end) begin
      hi_cnt_d    = '0;
      edge_cnt_d  = '0;
      full_d      = (hi_total == FULL_CNT);
      intensity_d = full_d ? SAT_V : hi_total[WIDTH-1:0];
      err_d       = (edge_total >= 3'd2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      hi_cnt_q    <= '0;
      edge_cnt_q  <= '0;
      intensity_q <= '0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      hi_cnt_q    <= hi_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      intensity_q <= intensity_d;
      err_q       <= err_d;
      full_q      <= full_d;
    end
  end

  assign intensity = intensity_q;
  assign err       = err_q;
  assign full      = full_q;

endmodule

// File: rtl/rgb_pwm_capture.sv
// Three-channel PWM duty decoder: a shared free-running window counter drives
// three pwm_capture channels and a one-cycle sample_valid strobe.
module rgb_pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red_pwm,
  input  logic             green_pwm,
  input  logic             blue_pwm,
  output logic [WIDTH-1:0] red_intensity,
  output logic [WIDTH-1:0] green_intensity,
  output logic [WIDTH-1:0] blue_intensity,
  output logic             sample_valid,
  output logic             red_err,
  output logic             green_err,
  output logic             blue_err,
  output logic             red_full,
  output logic             green_full,
  output logic             blue_full
);

  localparam int WIN_LEN = 1 << WIDTH;
  localparam int SAT     = WIN_LEN - 1;
  localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);

  logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic             sample_valid_q, sample_valid_d;
  logic             win_end;

  // Phase-free decode: any full-length window of a periodic source holds exactly duty highs.
  always_comb begin
    win_end        = (win_cnt_q == SAT_V);
    win_cnt_d      = win_cnt_q + WIDTH'(1);
    sample_valid_d = win_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt_q      <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      win_cnt_q      <= win_cnt_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample_valid = sample_valid_q;

  pwm_capture #(.WIDTH(WIDTH)) u_red (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (red_pwm),
    .win_end  (win_end),
    .intensity(red_intensity),
    .err      (red_err),
    .full     (red_full)
  );

  pwm_capture #(.WIDTH(WIDTH)) u_green (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (green_pwm),
    .win_end  (win_end),
    .intensity(green_intensity),
    .err      (green_err),
    .full     (green_full)
  );

  pwm_capture #(.WIDTH(WIDTH)) u_blue (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (blue_pwm),
    .win_end  (win_end),
    .intensity(blue_intensity),
    .err      (blue_err),
    .full     (blue_full)
  );

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Bench for rgb_pwm_capture: table of looped-back PWM scenarios, randomized
// sources, and a mid-window reset, all scored against a pin-history model.
module tb_rgb_pwm_capture;

  localparam int W = 8;
  localparam int N = 1 << W;

  logic         clk;
  logic         rst;
  logic         red_pwm, green_pwm, blue_pwm;
  logic [W-1:0] red_intensity, green_intensity, blue_intensity;
  logic         sample_valid;
  logic         red_err, green_err, blue_err;
  logic         red_full, green_full, blue_full;

  rgb_pwm_capture #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .red_pwm        (red_pwm),
    .green_pwm      (green_pwm),
    .blue_pwm       (blue_pwm),
    .red_intensity  (red_intensity),
    .green_intensity(green_intensity),
    .blue_intensity (blue_intensity),
    .sample_valid   (sample_valid),
    .red_err        (red_err),
    .green_err      (green_err),
    .blue_err       (blue_err),
    .red_full       (red_full),
    .green_full     (green_full),
    .blue_full      (blue_full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scenario table ----------------
  // duty: 0..N periodic high count, -1 two 5-cycle pulses per frame, -2 random glitches
  typedef struct {
    string name;
    int    duty     [3];
    int    off;
    int    exp_int  [3];
    int    exp_err  [3];
    int    exp_full [3];
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  // scenario state
  int         cur_duty [3];
  int         cur_off;
  bit         tbl_active;
  vec_t       cur_vec;
  logic [2:0] hist[$];   // hist[e] = pins applied before rising edge e, hist[0] is pre-release
  int         ecnt;

  task automatic add_vec(input string name, input int dr, input int dg, input int db,
                         input int off, input int er, input int eg, input int eb,
                         input int rerr, input int gerr, input int berr, input int fl);
    vec_t v;
    v.name = name;
    v.duty[0] = dr; v.duty[1] = dg; v.duty[2] = db;
    v.off = off;
    v.exp_int[0] = er; v.exp_int[1] = eg; v.exp_int[2] = eb;
    v.exp_err[0] = rerr; v.exp_err[1] = gerr; v.exp_err[2] = berr;
    v.exp_full[0] = fl; v.exp_full[1] = fl; v.exp_full[2] = fl;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus generator ----------------
  function automatic bit gen(input int mode, input int off, input int e);
    int pos;
    pos = e % N;
    if (mode == -1) return ((pos >= 10 && pos < 15) || (pos >= 100 && pos < 105));
    if (mode == -2) return ($urandom_range(0, 5) == 0);
    return (((e + off) % N) < mode);
  endfunction

  // ---------------- reference model ----------------
  // The decoder sees each pin two edges late; window k covers cycles k*N .. k*N+N-1.
  function automatic bit synced(input int ch, input int c);
    logic [2:0] v;
    if (c < 1) return 1'b0;
    v = hist[c-1];
    return v[ch];
  endfunction

  task automatic model(input int ch, input int k, output int inten, output int err, output int full);
    int highs, rises;
    highs = 0;
    rises = 0;
    for (int c = k * N; c < k * N + N; c++) begin
      if (synced(ch, c)) highs++;
      if (synced(ch, c) && !synced(ch, c - 1)) rises++;
    end
    full  = (highs == N) ? 1 : 0;
    inten = (highs >= N) ? N - 1 : highs;
    err   = (rises >= 2) ? 1 : 0;
  endtask

  function automatic int act_int(input int ch);
    case (ch)
      0:       return int'(red_intensity);
      1:       return int'(green_intensity);
      default: return int'(blue_intensity);
    endcase
  endfunction

  function automatic int act_err(input int ch);
    case (ch)
      0:       return int'(red_err);
      1:       return int'(green_err);
      default: return int'(blue_err);
    endcase
  endfunction

  function automatic int act_full(input int ch);
    case (ch)
      0:       return int'(red_full);
      1:       return int'(green_full);
      default: return int'(blue_full);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic restart();
    hist.delete();
    hist.push_back(3'b000);
    ecnt = 0;
    rst  = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample_valid"}, int'(sample_valid), 0);
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("%s_int%0d", tag, ch), act_int(ch), 0);
      check($sformatf("%s_err%0d", tag, ch), act_err(ch), 0);
      check($sformatf("%s_full%0d", tag, ch), act_full(ch), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    red_pwm = 1'b0; green_pwm = 1'b0; blue_pwm = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    restart();
  endtask

  // Drive pins for the next edge, advance one clock, then score the outputs.
  task automatic step(input string tag);
    logic [2:0] p;
    int k, mi, me, mf;
    for (int ch = 0; ch < 3; ch++) p[ch] = gen(cur_duty[ch], cur_off, ecnt + 1);
    hist.push_back(p);
    red_pwm = p[0]; green_pwm = p[1]; blue_pwm = p[2];
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    if (ecnt % N == 0) begin
      k = ecnt / N - 1;
      check({tag, "_sample_valid_hi"}, int'(sample_valid), 1);
      for (int ch = 0; ch < 3; ch++) begin
        model(ch, k, mi, me, mf);
        check($sformatf("%s_w%0d_int%0d", tag, k, ch), act_int(ch), mi);
        check($sformatf("%s_w%0d_err%0d", tag, k, ch), act_err(ch), me);
        check($sformatf("%s_w%0d_full%0d", tag, k, ch), act_full(ch), mf);
        if (tbl_active && k >= 1) begin
          check($sformatf("%s_w%0d_tbl_int%0d", tag, k, ch), act_int(ch), cur_vec.exp_int[ch]);
          check($sformatf("%s_w%0d_tbl_err%0d", tag, k, ch), act_err(ch), cur_vec.exp_err[ch]);
          check($sformatf("%s_w%0d_tbl_full%0d", tag, k, ch), act_full(ch), cur_vec.exp_full[ch]);
        end
      end
    end else begin
      check({tag, "_sample_valid_lo"}, int'(sample_valid), 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0;
    red_pwm = 1'b0; green_pwm = 1'b0; blue_pwm = 1'b0;
    tbl_active = 1'b0;
    cur_off = 0;
    ecnt = 0;
    for (int ch = 0; ch < 3; ch++) cur_duty[ch] = 0;

    add_vec("loopback",  'h40, 'h80, 'h01,   0, 'h40, 'h80, 'h01, 0, 0, 0, 0);
    add_vec("held0",         0,    0,    0,   0,    0,    0,    0, 0, 0, 0, 0);
    add_vec("held1",         N,    N,    N,   0, 'hFF, 'hFF, 'hFF, 0, 0, 0, 1);
    add_vec("off0",      'h20, 'h20, 'h20,   0, 'h20, 'h20, 'h20, 0, 0, 0, 0);
    add_vec("off100",    'h20, 'h20, 'h20, 100, 'h20, 'h20, 'h20, 0, 0, 0, 0);
    add_vec("off255",    'h20, 'h20, 'h20, 255, 'h20, 'h20, 'h20, 0, 0, 0, 0);
    add_vec("glitch_r",     -1, 'h80, 'h40,  37, 'h0A, 'h80, 'h40, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      cur_vec    = tbl[i];
      tbl_active = 1'b1;
      cur_off    = cur_vec.off;
      for (int ch = 0; ch < 3; ch++) cur_duty[ch] = cur_vec.duty[ch];
      do_reset();
      for (int c = 0; c < 3 * N; c++) step(cur_vec.name);
    end
    tbl_active = 1'b0;

    // randomized sources, scored by the model only
    for (int r = 0; r < 6; r++) begin
      cur_off = $urandom_range(0, N - 1);
      for (int ch = 0; ch < 3; ch++) begin
        case ($urandom_range(0, 3))
          0:       cur_duty[ch] = -2;
          1:       cur_duty[ch] = N;
          default: cur_duty[ch] = $urandom_range(0, N - 1);
        endcase
      end
      do_reset();
      for (int c = 0; c < 3 * N; c++) step($sformatf("rand%0d", r));
    end

    // reset in the middle of a window
    cur_off = 0;
    cur_duty[0] = 'h40; cur_duty[1] = 'h80; cur_duty[2] = 'h01;
    do_reset();
    for (int c = 0; c < N + 130; c++) step("pre_midrst");
    check("midrst_win_pos", ecnt % N, 130);
    rst = 1'b0;
    #1;
    check_zero("midrst_now");
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_sample_valid", int'(sample_valid), 0);
    end
    restart();
    for (int c = 0; c < 2 * N; c++) step("post_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
